// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared writeback definitions: register-bank address/data widths and the queued write entry.
package reg_writeback_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// In-order writeback queue: two pushes per cycle (port a is older), one pop, and a
// dest match across occupied entries. Head outputs are zeroed while empty.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_a_i,
    input  logic [ADDR_W-1:0]       dest_a_i,
    input  logic [DATA_W-1:0]       data_a_i,
    input  logic                    push_b_i,
    input  logic [ADDR_W-1:0]       dest_b_i,
    input  logic [DATA_W-1:0]       data_b_i,
    input  logic                    pop_i,
    input  logic [ADDR_W-1:0]       hz_addr_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    head_vld_o,
    output logic [ADDR_W-1:0]       head_dest_o,
    output logic [DATA_W-1:0]       head_data_o,
    output logic                    hz_match_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_b_s;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  off_s [DEPTH];
    logic              pop_s;

    assign pop_s      = pop_i && (count_q != '0);
    assign wr_ptr_b_s = wr_ptr_q + PTR_W'(push_a_i);

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
        wr_ptr_d = wr_ptr_b_s + PTR_W'(push_b_i);
        count_d  = count_q - CNT_W'(pop_s) + CNT_W'(push_a_i) + CNT_W'(push_b_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed while it is counted as occupied.
    always_ff @(posedge clk) begin
        if (push_a_i) begin
            dest_q[wr_ptr_q] <= dest_a_i;
            data_q[wr_ptr_q] <= data_a_i;
        end
        if (push_b_i) begin
            dest_q[wr_ptr_b_s] <= dest_b_i;
            data_q[wr_ptr_b_s] <= data_b_i;
        end
    end

    assign count_o     = count_q;
    assign head_vld_o  = (count_q != '0);
    assign head_dest_o = head_vld_o ? dest_q[rd_ptr_q] : '0;
    assign head_data_o = head_vld_o ? data_q[rd_ptr_q] : '0;

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        hz_match_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off_s[i] = PTR_W'(i) - rd_ptr_q;
            if ((hz_addr_i != '0) && (dest_q[i] == hz_addr_i) && (CNT_W'(off_s[i]) < count_q)) begin
                hz_match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-bank write initiator: merges MEM and ALU results into an in-order queue drained one
// entry per cycle. One cycle from accept to bank write; ready reflects the slot freed by this cycle's pop.
module reg_writeback_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = reg_writeback_ctrl_pkg::DATA_W,
    parameter int ADDR_W = reg_writeback_ctrl_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADDR_W-1:0]       mem_dest,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_dest,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    wb_write_en,
    output logic [ADDR_W-1:0]       wb_dest,
    output logic [DATA_W-1:0]       wb_data,
    input  logic [ADDR_W-1:0]       hz_addr,
    output logic                    hz_match,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] free_s;
    logic             head_vld_s;
    logic             push_mem_s;
    logic             push_alu_s;

    // The head is popped every edge, so its slot is already free for this cycle's pushes.
    assign free_s = CNT_W'(DEPTH) - count + CNT_W'(head_vld_s);

    assign mem_ready = (free_s >= CNT_W'(1));
    assign alu_ready = (free_s >= CNT_W'(2)) ||
                       ((free_s >= CNT_W'(1)) && !(mem_valid && (mem_dest != '0)));

    // Register 0 is hardwired: such results handshake normally but are dropped here.
    assign push_mem_s = mem_valid && mem_ready && (mem_dest != '0);
    assign push_alu_s = alu_valid && alu_ready && (alu_dest != '0);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wb_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_a_i    (push_mem_s),
        .dest_a_i    (mem_dest),
        .data_a_i    (mem_data),
        .push_b_i    (push_alu_s),
        .dest_b_i    (alu_dest),
        .data_b_i    (alu_data),
        .pop_i       (head_vld_s),
        .hz_addr_i   (hz_addr),
        .count_o     (count),
        .head_vld_o  (head_vld_s),
        .head_dest_o (wb_dest),
        .head_data_o (wb_data),
        .hz_match_o  (hz_match)
    );

    assign wb_write_en = head_vld_s;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_reg_writeback_ctrl;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0, alu_valid = 1'b0;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_dest = '0, alu_dest = '0, hz_addr = '0;
    logic [31:0] mem_data = '0, alu_data = '0;
    logic        wb_write_en, hz_match;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;
    ent_t mq[$];

    always #5 clk = ~clk;

    reg_writeback_ctrl #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .wb_write_en(wb_write_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .hz_addr(hz_addr), .hz_match(hz_match), .count(count)
    );

    // ---------------- reference model (queue of pending bank writes) ----------------
    function automatic int m_free();
        int n = mq.size();
        return DEPTH - n + ((n > 0) ? 1 : 0);
    endfunction

    function automatic bit m_mem_rdy();
        return m_free() >= 1;
    endfunction

    function automatic bit m_alu_rdy();
        return (m_free() >= 2) || ((m_free() >= 1) && !(mem_valid && mem_dest != 0));
    endfunction

    function automatic bit m_hz();
        if (hz_addr == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].dest == hz_addr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [43:0] m_outs();
        ent_t h = (mq.size() > 0) ? mq[0] : '0;
        return {mq.size() > 0, h.dest, h.data, 3'(mq.size()), m_mem_rdy(), m_alu_rdy(), m_hz()};
    endfunction

    // Advance model and clock together; reports which offers the model accepts.
    task automatic step(output bit mem_acc, output bit alu_acc);
        mem_acc = mem_valid && m_mem_rdy();
        alu_acc = alu_valid && m_alu_rdy();
        if (rst) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (mem_acc && mem_dest != 0) mq.push_back({mem_dest, mem_data});
            if (alu_acc && alu_dest != 0) mq.push_back({alu_dest, alu_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bit a, b;
        step(a, b);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; hz_addr = 5'd3;
        tick(); tick();
        rst = 1'b0;
        #1;
        vectors++;
        if ({count, wb_write_en, wb_dest, wb_data, hz_match} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_state: got cnt=%0d en=%b dest=%0d data=%h hz=%b want all zero",
                     count, wb_write_en, wb_dest, wb_data, hz_match);
        end
    endtask

    task automatic test_single();
        mem_valid = 1'b1; mem_dest = 5'd3; mem_data = 32'hDEADBEEF;
        #1;
        vectors++;
        if (count !== 3'd0 || wb_write_en !== 1'b0) begin
            miscompares++; $display("FAIL single_before: got cnt=%0d en=%b want 0/0", count, wb_write_en);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        vectors++;
        if ({wb_write_en, wb_dest, wb_data, count} !== {1'b1, 5'd3, 32'hDEADBEEF, 3'd1}) begin
            miscompares++;
            $display("FAIL single_write: got en=%b dest=%0d data=%h cnt=%0d want 1/3/deadbeef/1",
                     wb_write_en, wb_dest, wb_data, count);
        end
        tick();
        #1;
        vectors++;
        if (wb_write_en !== 1'b0 || count !== 3'd0) begin
            miscompares++; $display("FAIL single_after: got en=%b cnt=%0d want 0/0", wb_write_en, count);
        end
    endtask

    task automatic test_dual();
        mem_valid = 1'b1; mem_dest = 5'd5; mem_data = 32'h11;
        alu_valid = 1'b1; alu_dest = 5'd6; alu_data = 32'h22;
        #1;
        vectors++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
            miscompares++; $display("FAIL dual_ready: got mem=%b alu=%b want 1/1", mem_ready, alu_ready);
        end
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        vectors++;
        if ({wb_write_en, wb_dest, wb_data, count} !== {1'b1, 5'd5, 32'h11, 3'd2}) begin
            miscompares++;
            $display("FAIL dual_first: got en=%b dest=%0d data=%h cnt=%0d want 1/5/11/2",
                     wb_write_en, wb_dest, wb_data, count);
        end
        tick();
        #1;
        vectors++;
        if ({wb_write_en, wb_dest, wb_data, count} !== {1'b1, 5'd6, 32'h22, 3'd1}) begin
            miscompares++;
            $display("FAIL dual_second: got en=%b dest=%0d data=%h cnt=%0d want 1/6/22/1",
                     wb_write_en, wb_dest, wb_data, count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ent_t sent[$];
        ent_t seen[$];
        int   maxc = 0;
        int   seq = 0;
        bit   ma, aa, order_ok;
        mem_valid = 1'b1; mem_dest = 5'(seq % 31 + 1); mem_data = $urandom; seq++;
        alu_valid = 1'b1; alu_dest = 5'(seq % 31 + 1); alu_data = $urandom; seq++;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (wb_write_en) seen.push_back({wb_dest, wb_data});
            if (int'(count) > maxc) maxc = int'(count);
            if (count == 3'd4) begin
                vectors++;
                if (alu_ready !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_full_alu_ready: cycle %0d got %b want 0", c, alu_ready);
                end
            end
            step(ma, aa);
            if (ma) begin sent.push_back({mem_dest, mem_data}); mem_dest = 5'(seq % 31 + 1); mem_data = $urandom; seq++; end
            if (aa) begin sent.push_back({alu_dest, alu_data}); alu_dest = 5'(seq % 31 + 1); alu_data = $urandom; seq++; end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (wb_write_en) seen.push_back({wb_dest, wb_data});
            tick();
        end
        vectors++;
        if (maxc != DEPTH) begin
            miscompares++; $display("FAIL b2b_max_count: got %0d want %0d", maxc, DEPTH);
        end
        vectors++;
        order_ok = (seen.size() == sent.size());
        if (order_ok) foreach (sent[i]) if (seen[i] !== sent[i]) order_ok = 1'b0;
        if (!order_ok) begin
            miscompares++; $display("FAIL b2b_order: got %0d writes want %0d in accept order", seen.size(), sent.size());
        end
    endtask

    task automatic test_reg0();
        alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'hFFFFFFFF;
        #1;
        vectors++;
        if (alu_ready !== 1'b1) begin
            miscompares++; $display("FAIL reg0_ready: got %b want 1", alu_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            vectors++;
            if (wb_write_en !== 1'b0 || count !== 3'd0) begin
                miscompares++; $display("FAIL reg0_dropped: cycle %0d got en=%b cnt=%0d want 0/0", c, wb_write_en, count);
            end
        end
        alu_valid = 1'b0;
    endtask

    task automatic test_hazard();
        hz_addr = 5'd7;
        mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 32'h77;
        alu_valid = 1'b1; alu_dest = 5'd8; alu_data = 32'h88;
        #1;
        vectors++;
        if (hz_match !== 1'b0) begin
            miscompares++; $display("FAIL hz_inflight: got %b want 0", hz_match);
        end
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        vectors++;
        if (hz_match !== 1'b1) begin
            miscompares++; $display("FAIL hz_head7: got %b want 1", hz_match);
        end
        hz_addr = 5'd8;
        #1;
        vectors++;
        if (hz_match !== 1'b1) begin
            miscompares++; $display("FAIL hz_tail8: got %b want 1", hz_match);
        end
        tick();
        hz_addr = 5'd7;
        #1;
        vectors++;
        if (hz_match !== 1'b0) begin
            miscompares++; $display("FAIL hz_drained7: got %b want 0", hz_match);
        end
        tick();
        hz_addr = 5'd0; alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h5;
        #1;
        vectors++;
        if (hz_match !== 1'b0) begin
            miscompares++; $display("FAIL hz_reg0: got %b want 0", hz_match);
        end
        tick();
        #1;
        vectors++;
        if (hz_match !== 1'b0 || count !== 3'd0) begin
            miscompares++; $display("FAIL hz_reg0_after: got hz=%b cnt=%0d want 0/0", hz_match, count);
        end
        alu_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        mem_valid = 1'b1; mem_dest = 5'd10; mem_data = 32'hA;
        alu_valid = 1'b1; alu_dest = 5'd11; alu_data = 32'hB;
        tick();
        mem_dest = 5'd12; mem_data = 32'hC;
        alu_dest = 5'd13; alu_data = 32'hD;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0; hz_addr = 5'd12;
        #1;
        vectors++;
        if (count !== 3'd3) begin
            miscompares++; $display("FAIL midrst_count3: got %0d want 3", count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if ({count, wb_write_en, hz_match} !== 5'd0) begin
            miscompares++; $display("FAIL midrst_cleared: got cnt=%0d en=%b hz=%b want 0/0/0", count, wb_write_en, hz_match);
        end
        mem_valid = 1'b1; mem_dest = 5'd9; mem_data = 32'h99;
        tick();
        mem_valid = 1'b0;
        #1;
        vectors++;
        if ({wb_write_en, wb_dest, wb_data} !== {1'b1, 5'd9, 32'h99}) begin
            miscompares++; $display("FAIL midrst_newwrite: got en=%b dest=%0d data=%h want 1/9/99", wb_write_en, wb_dest, wb_data);
        end
        tick();
    endtask

    task automatic test_random();
        bit          ma, aa;
        logic [43:0] got, want;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!mem_valid || mem_ready === 1'bx || c == 0 || 1'b1) begin end
            hz_addr = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 59) == 0);
            #1;
            vectors++;
            got  = {wb_write_en, wb_dest, wb_data, count, mem_ready, alu_ready, hz_match};
            want = m_outs();
            if (got !== want) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h want %h (en,dest,data,cnt,mrdy,ardy,hz)", c, got, want);
            end
            step(ma, aa);
            if (!mem_valid || ma) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_dest = 5'($urandom_range(0, 7)); mem_data = $urandom;
            end
            if (!alu_valid || aa) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_dest = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
        end
        rst = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_reg0();
        test_hazard();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
